// File: rtl/text_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : text_pkg
// Purpose  : Shared constants, control codes, controller state encoding and
//            the cell-address helper for the text buffer controller.
// Revision : 1.0 - initial release
// ============================================================================
package text_pkg;

    localparam int COLS   = 40;
    localparam int ROWS   = 15;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 4;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 10;
    localparam int CELLS  = ROWS * COLS;

    localparam logic [ID_W-1:0] BLANK_ID = 8'h20;

    localparam logic [ID_W-1:0] CC_CR = 8'h0D;
    localparam logic [ID_W-1:0] CC_LF = 8'h0A;
    localparam logic [ID_W-1:0] CC_BS = 8'h08;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SCROLL  = 3'd3,
        ST_BLANKLN = 3'd4
    } tb_state_t;

    // row*COLS + col, widened to the full address width before the multiply
    // so the product is never truncated.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : text_buffer_ctrl_if
// Purpose  : Byte-stream valid/ready handshake from the UART/keyboard
//            receiver into the text buffer controller.
//   rx_data  : incoming character byte (source -> sink)
//   rx_valid : rx_data valid          (source -> sink)
//   rx_ready : sink accepts this cycle (sink -> source)
// Revision : 1.0 - initial release
// ============================================================================
interface text_buffer_ctrl_if;
    import text_pkg::*;

    logic [ID_W-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface
`default_nettype wire

// File: rtl/text_buffer_ctrl_char_ram.sv
`default_nettype none
// ============================================================================
// Module   : char_ram
// Purpose  : Character-cell store, true dual-port with registered reads.
//   clk, rst_n : clock / async active-low reset (port A output register only)
//   a_addr     : display read address
//   a_q        : display read data, one cycle after a_addr
//   b_addr     : controller address
//   b_we       : controller write enable
//   b_wdata    : controller write data
//   b_q        : controller read data; on a write returns the written data
// Revision : 1.0 - initial release
// ============================================================================
module char_ram
    import text_pkg::*;
#(
    parameter int RAM_DEPTH = CELLS,
    parameter int RAM_AW    = ADDR_W,
    parameter int RAM_DW    = ID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RAM_AW-1:0] a_addr,
    output logic [RAM_DW-1:0] a_q,
    input  logic [RAM_AW-1:0] b_addr,
    input  logic              b_we,
    input  logic [RAM_DW-1:0] b_wdata,
    output logic [RAM_DW-1:0] b_q
);

    logic [RAM_DW-1:0] r_mem [RAM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
        end else begin
            a_q <= r_mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (b_we) begin
            r_mem[b_addr] <= b_wdata;
            b_q           <= b_wdata;
        end else begin
            b_q           <= r_mem[b_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_buffer_ctrl
// Purpose  : Minimal terminal front end for a 40x15 character buffer:
//            cursor tracking, wrap, CR/LF, backspace, scroll, clear-screen,
//            plus a registered display read port for the pixel encoder.
//   clk, rst_n       : clock / async active-low reset
//   rx (slave)       : incoming byte stream, valid/ready
//   clear            : one-cycle pulse, blank screen and home cursor
//   rd_row, rd_col   : display read cell
//   rd_char          : cell content, one cycle after rd_row/rd_col
//   cursor_row/col   : current cursor position
//   busy             : high while clearing, scrolling or blanking a line
// Revision : 1.0 - initial release
// ============================================================================
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    text_buffer_ctrl_if.slave   rx,
    input  logic                clear,
    input  logic [ROW_W-1:0]    rd_row,
    input  logic [COL_W-1:0]    rd_col,
    output logic [ID_W-1:0]     rd_char,
    output logic [ROW_W-1:0]    cursor_row,
    output logic [COL_W-1:0]    cursor_col,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR     = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] c_LINE          = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  c_LAST_COL      = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  c_LAST_ROW      = ROW_W'(ROWS - 1);

    tb_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic              r_phase, w_phase_nxt;
    logic [ID_W-1:0]   r_byte,  w_byte_nxt;
    logic [ROW_W-1:0]  r_row,   w_row_nxt;
    logic [COL_W-1:0]  r_col,   w_col_nxt;
    logic              r_clear_pend, w_pend_nxt;

    logic [ADDR_W-1:0] w_cur_addr;
    logic [ADDR_W-1:0] w_b_addr;
    logic              w_b_we;
    logic [ID_W-1:0]   w_b_wdata;
    logic [ID_W-1:0]   w_b_q;
    logic              w_newline;
    logic              w_rx_ready;
    logic              w_busy;

    char_ram u_char_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_addr  (cell_addr(rd_row, rd_col)),
        .a_q     (rd_char),
        .b_addr  (w_b_addr),
        .b_we    (w_b_we),
        .b_wdata (w_b_wdata),
        .b_q     (w_b_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLEAR;
            r_addr       <= '0;
            r_phase      <= 1'b0;
            r_byte       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_clear_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_phase      <= w_phase_nxt;
            r_byte       <= w_byte_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_clear_pend <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_byte_nxt  = r_byte;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        // Any clear pulse outside IDLE/CLEAR is remembered; repeats collapse.
        w_pend_nxt  = r_clear_pend | clear;
        w_cur_addr  = cell_addr(r_row, r_col);
        w_b_addr    = r_addr;
        w_b_we      = 1'b0;
        w_b_wdata   = BLANK_ID;
        w_newline   = 1'b0;
        w_rx_ready  = 1'b0;
        w_busy      = 1'b1;

        case (r_state)
            ST_CLEAR: begin
                w_pend_nxt = 1'b0;
                w_b_we     = 1'b1;
                if (clear) begin
                    w_addr_nxt = '0;
                end else if (r_addr == c_LAST_ADDR) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                end
            end

            ST_IDLE: begin
                w_busy = 1'b0;
                // Ready is withheld while a clear is due so a byte arriving
                // with the clear is never half-accepted.
                w_rx_ready = !(r_clear_pend || clear);
                if (r_clear_pend || clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_addr_nxt  = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end else if (rx.rx_valid) begin
                    w_byte_nxt  = rx.rx_data;
                    w_state_nxt = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
                w_b_addr    = w_cur_addr;
                if (r_byte >= 8'h20 && r_byte <= 8'h7E) begin
                    w_b_we    = 1'b1;
                    w_b_wdata = r_byte;
                    if (r_col == c_LAST_COL) begin
                        w_newline = 1'b1;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end else if (r_byte == CC_CR) begin
                    w_col_nxt = '0;
                end else if (r_byte == CC_LF) begin
                    w_newline = 1'b1;
                end else if (r_byte == CC_BS) begin
                    // The cell before the cursor is always linear address - 1,
                    // including the step back to the previous row's last cell.
                    if (r_col != '0) begin
                        w_col_nxt = r_col - 1'b1;
                        w_b_we    = 1'b1;
                        w_b_addr  = w_cur_addr - 1'b1;
                    end else if (r_row != '0) begin
                        w_row_nxt = r_row - 1'b1;
                        w_col_nxt = c_LAST_COL;
                        w_b_we    = 1'b1;
                        w_b_addr  = w_cur_addr - 1'b1;
                    end
                end

                if (w_newline) begin
                    w_col_nxt = '0;
                    if (r_row == c_LAST_ROW) begin
                        w_state_nxt = ST_SCROLL;
                        w_addr_nxt  = c_LINE;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end

            ST_SCROLL: begin
                // r_addr is the source cell; phase 0 reads it, phase 1 writes
                // the registered read data one line up.
                if (!r_phase) begin
                    w_b_addr    = r_addr;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_b_addr    = r_addr - c_LINE;
                    w_b_we      = 1'b1;
                    w_b_wdata   = w_b_q;
                    w_phase_nxt = 1'b0;
                    if (r_addr == c_LAST_ADDR) begin
                        w_state_nxt = ST_BLANKLN;
                        w_addr_nxt  = c_LAST_ROW_BASE;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end

            ST_BLANKLN: begin
                w_b_we = 1'b1;
                if (r_addr == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_CLEAR;
                w_addr_nxt  = '0;
            end
        endcase
    end

    assign rx.rx_ready  = w_rx_ready;
    assign busy         = w_busy;
    assign cursor_row   = r_row;
    assign cursor_col   = r_col;

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_buffer_ctrl
// Purpose  : Directed self-checking bench for text_buffer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_buffer_ctrl;
    import text_pkg::*;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             clear  = 1'b0;
    logic [ROW_W-1:0] rd_row = '0;
    logic [COL_W-1:0] rd_col = '0;
    logic [ID_W-1:0]  rd_char;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic             busy;

    int total = 0;
    int bad   = 0;

    text_buffer_ctrl_if rx_bus ();

    text_buffer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_bus),
        .clear      (clear),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_char    (rd_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic count_busy(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while (!rx_bus.rx_ready && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        rx_bus.rx_data  = b;
        rx_bus.rx_valid = 1'b1;
        @(negedge clk);
        rx_bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        rd_row = ROW_W'(r);
        rd_col = COL_W'(c);
        @(negedge clk);
        v = rd_char;
    endtask

    task automatic pulse_clear_and_wait(output int n);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        count_busy(3000, n);
    endtask

    function automatic logic [7:0] scrolled_cell(input int r, input int c);
        if (r < 13)  return 8'(8'h42 + r);
        if (r == 13) return (c < 5) ? 8'h4F : 8'h20;
        return 8'h20;
    endfunction

    // ------------------------------ tests -----------------------------------
    task automatic test_reset();
        int n, errs;
        logic [7:0] v;
        repeat (3) @(negedge clk);
        total++; if (rx_bus.rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_bus.rx_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin bad++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        total++; if (rd_char !== 8'h00) begin bad++; $display("FAIL reset_rd_char: got %h want 00", rd_char); end
        rst_n = 1'b1;
        count_busy(3000, n);
        total++; if (n !== 600) begin bad++; $display("FAIL reset_clear_len: got %0d want 600", n); end
        total++; if (rx_bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", rx_bus.rx_ready); end
        errs = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                if (v !== 8'h20) errs++;
            end
        total++; if (errs !== 0) begin bad++; $display("FAIL reset_screen_blank: got %0d bad cells want 0", errs); end
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin bad++; $display("FAIL reset_cursor_after: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_clear_restart();
        int n = 0;
        clear = 1'b1;
        @(negedge clk);
        while (busy && n < 3000) begin
            clear = (n == 200);
            n++;
            @(negedge clk);
        end
        clear = 1'b0;
        total++; if (n !== 801) begin bad++; $display("FAIL clear_restart_len: got %0d want 801", n); end
    endtask

    task automatic test_two_bytes();
        logic [4:0] pat;
        logic [7:0] v;
        rx_bus.rx_valid = 1'b1; rx_bus.rx_data = 8'h41; pat[4] = rx_bus.rx_ready;
        @(negedge clk); pat[3] = rx_bus.rx_ready; rx_bus.rx_data = 8'h42;
        @(negedge clk); pat[2] = rx_bus.rx_ready;
        @(negedge clk); pat[1] = rx_bus.rx_ready;
        @(negedge clk); pat[0] = rx_bus.rx_ready; rx_bus.rx_valid = 1'b0;
        total++; if (pat !== 5'b10101) begin bad++; $display("FAIL ab_ready_pattern: got %b want 10101", pat); end
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd2) begin bad++; $display("FAIL ab_cursor: got (%0d,%0d) want (0,2)", cursor_row, cursor_col); end
        read_cell(0, 0, v);
        total++; if (v !== 8'h41) begin bad++; $display("FAIL ab_cell00: got %h want 41", v); end
        read_cell(0, 1, v);
        total++; if (v !== 8'h42) begin bad++; $display("FAIL ab_cell01: got %h want 42", v); end
    endtask

    task automatic test_wrap_and_controls();
        int n, errs;
        logic [7:0] v;
        pulse_clear_and_wait(n);
        total++; if (n !== 600) begin bad++; $display("FAIL wrap_clear_len: got %0d want 600", n); end
        for (int i = 0; i < COLS; i++) send_byte(8'h58);
        total++; if (cursor_row !== 4'd1 || cursor_col !== 6'd0) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (1,0)", cursor_row, cursor_col); end
        errs = 0;
        for (int c = 0; c < COLS; c++) begin
            read_cell(0, c, v);
            if (v !== 8'h58) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL wrap_row0: got %0d bad cells want 0", errs); end
        read_cell(1, 0, v);
        total++; if (v !== 8'h20) begin bad++; $display("FAIL wrap_cell10: got %h want 20", v); end

        send_byte(CC_BS);
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd39) begin bad++; $display("FAIL bs_wrap_cursor: got (%0d,%0d) want (0,39)", cursor_row, cursor_col); end
        read_cell(0, 39, v);
        total++; if (v !== 8'h20) begin bad++; $display("FAIL bs_wrap_cell: got %h want 20", v); end
        read_cell(0, 38, v);
        total++; if (v !== 8'h58) begin bad++; $display("FAIL bs_neighbour_cell: got %h want 58", v); end

        send_byte(CC_CR);
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin bad++; $display("FAIL cr_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(CC_BS);
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin bad++; $display("FAIL noop_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        read_cell(0, 0, v);
        total++; if (v !== 8'h58) begin bad++; $display("FAIL noop_cell00: got %h want 58", v); end
        send_byte(8'h7E);
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd1) begin bad++; $display("FAIL tilde_cursor: got (%0d,%0d) want (0,1)", cursor_row, cursor_col); end
        read_cell(0, 0, v);
        total++; if (v !== 8'h7E) begin bad++; $display("FAIL tilde_cell: got %h want 7e", v); end
    endtask

    task automatic test_scroll();
        int n, errs, errs14;
        logic [7:0] v;
        pulse_clear_and_wait(n);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < ((r == ROWS - 1) ? 5 : COLS); c++)
                send_byte(8'(8'h41 + r));
        total++; if (cursor_row !== 4'd14 || cursor_col !== 6'd5) begin bad++; $display("FAIL fill_cursor: got (%0d,%0d) want (14,5)", cursor_row, cursor_col); end
        send_byte(CC_LF);
        count_busy(3000, n);
        total++; if (n !== 1160) begin bad++; $display("FAIL scroll_len: got %0d want 1160", n); end
        total++; if (cursor_row !== 4'd14 || cursor_col !== 6'd0) begin bad++; $display("FAIL scroll_cursor: got (%0d,%0d) want (14,0)", cursor_row, cursor_col); end
        errs = 0; errs14 = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                if (v !== scrolled_cell(r, c)) begin
                    if (r == ROWS - 1) errs14++; else errs++;
                end
            end
        total++; if (errs !== 0) begin bad++; $display("FAIL scroll_rows_moved: got %0d bad cells want 0", errs); end
        total++; if (errs14 !== 0) begin bad++; $display("FAIL scroll_last_row_blank: got %0d bad cells want 0", errs14); end
    endtask

    task automatic test_clear_during_scroll();
        int n = 0, ready_seen = 0, errs = 0;
        logic [7:0] v;
        send_byte(CC_LF);
        while (busy && n < 3000) begin
            clear = (n == 300);
            if (rx_bus.rx_ready) ready_seen++;
            n++;
            @(negedge clk);
        end
        clear = 1'b0;
        total++; if (n !== 1160) begin bad++; $display("FAIL cds_scroll_len: got %0d want 1160", n); end
        total++; if (rx_bus.rx_ready !== 1'b0 || ready_seen !== 0) begin bad++; $display("FAIL cds_ready_blocked: got ready=%b seen=%0d want 0/0", rx_bus.rx_ready, ready_seen); end
        @(negedge clk);
        count_busy(3000, n);
        total++; if (n !== 600) begin bad++; $display("FAIL cds_clear_len: got %0d want 600", n); end
        total++; if (rx_bus.rx_ready !== 1'b1) begin bad++; $display("FAIL cds_ready_after: got %b want 1", rx_bus.rx_ready); end
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin bad++; $display("FAIL cds_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                if (v !== 8'h20) errs++;
            end
        total++; if (errs !== 0) begin bad++; $display("FAIL cds_screen_blank: got %0d bad cells want 0", errs); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        send_byte(8'h51);
        rd_row = 4'd3;
        rd_col = 6'd7;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (300) @(negedge clk);
        total++; if (rd_char !== 8'h20) begin bad++; $display("FAIL rmc_pre_rd_char: got %h want 20", rd_char); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rx_bus.rx_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rmc_ready_busy: got %b/%b want 0/1", rx_bus.rx_ready, busy); end
        total++; if (rd_char !== 8'h00) begin bad++; $display("FAIL rmc_rd_char: got %h want 00", rd_char); end
        total++; if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin bad++; $display("FAIL rmc_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy(3000, n);
        total++; if (n !== 600) begin bad++; $display("FAIL rmc_restart_len: got %0d want 600", n); end
        total++; if (rx_bus.rx_ready !== 1'b1) begin bad++; $display("FAIL rmc_ready_after: got %b want 1", rx_bus.rx_ready); end
    endtask

    initial begin
        rx_bus.rx_valid = 1'b0;
        rx_bus.rx_data  = 8'h00;
        test_reset();
        test_clear_restart();
        test_two_bytes();
        test_wrap_and_controls();
        test_scroll();
        test_clear_during_scroll();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
